// File: rtl/mesi_isc_pkg.sv
// Shared definitions for the MESI intersection controller: broadcast request and
// cbus command encodings, arbiter FSM states and default widths.
package mesi_isc_pkg;

    localparam int ADDR_WIDTH_DEF       = 32;
    localparam int BROAD_TYPE_WIDTH_DEF = 2;
    localparam int BROAD_ID_WIDTH_DEF   = 5;

    // Value 3 is undefined and is handled as NOP by consumers.
    typedef enum logic [1:0] {
        BREQ_NOP = 2'd0,
        BREQ_WR  = 2'd1,
        BREQ_RD  = 2'd2
    } breq_type_e;

    typedef enum logic [2:0] {
        CBUS_NOP      = 3'd0,
        CBUS_WR_SNOOP = 3'd1,
        CBUS_RD_SNOOP = 3'd2,
        CBUS_EN_WR    = 3'd3,
        CBUS_EN_RD    = 3'd4
    } cbus_cmd_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_GAP  = 1'b1
    } breq_arb_state_e;

endpackage

// File: rtl/mesi_isc_rr_arb4.sv
// Combinational 4-way round-robin picker: the search starts just after the last
// grant and takes the first requesting input.
module mesi_isc_rr_arb4 (
    input  logic [3:0] req_i,
    input  logic [1:0] last_i,
    output logic [3:0] gnt_onehot_o,
    output logic [1:0] gnt_id_o,
    output logic       any_o
);

    logic [1:0] idx;
    logic       found;

    always_comb begin
        gnt_onehot_o = '0;
        gnt_id_o     = '0;
        any_o        = |req_i;
        idx          = '0;
        found        = 1'b0;
        // Offset 4 wraps back to last_i, so the previous winner has lowest priority.
        for (int i = 1; i <= 4; i++) begin
            idx = last_i + 2'(i);
            if (!found && req_i[idx]) begin
                found             = 1'b1;
                gnt_id_o          = idx;
                gnt_onehot_o[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mesi_isc_breq_arb.sv
// Broadcast-request arbiter: picks one per-CPU FIFO head round-robin, pops it, and
// writes a stamped broadcast into the broadcast FIFO.
module mesi_isc_breq_arb
    import mesi_isc_pkg::*;
#(
    parameter int ADDR_WIDTH       = ADDR_WIDTH_DEF,
    parameter int BROAD_TYPE_WIDTH = BROAD_TYPE_WIDTH_DEF,
    parameter int BROAD_ID_WIDTH   = BROAD_ID_WIDTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [3:0]                    breq_valid_i,
    input  logic [4*BROAD_TYPE_WIDTH-1:0] breq_type_array_i,
    input  logic [4*ADDR_WIDTH-1:0]       breq_addr_array_i,
    output logic [3:0]                    breq_ack_o,
    input  logic                          broad_fifo_full_i,
    output logic                          broad_fifo_wr_o,
    output logic [BROAD_TYPE_WIDTH-1:0]   broad_type_o,
    output logic [ADDR_WIDTH-1:0]         broad_addr_o,
    output logic [1:0]                    broad_cpu_id_o,
    output logic [BROAD_ID_WIDTH-1:0]     broad_id_o
);

    localparam logic [BROAD_TYPE_WIDTH-1:0] TYPE_WR = BROAD_TYPE_WIDTH'(BREQ_WR);
    localparam logic [BROAD_TYPE_WIDTH-1:0] TYPE_RD = BROAD_TYPE_WIDTH'(BREQ_RD);

    // Handshake: a CPU head is taken when breq_valid_i[n] is sampled high in IDLE with
    // the broadcast FIFO not full; the one-cycle breq_ack_o pulse is the pop, and
    // broad_fifo_wr_o pulses in that same cycle unless the head was a NOP.
    breq_arb_state_e             state_q, state_d;
    logic [1:0]                  last_grant_q, last_grant_d;
    logic [BROAD_ID_WIDTH-1:0]   id_cnt_q, id_cnt_d;
    logic [3:0]                  ack_q, ack_d;
    logic                        wr_q, wr_d;
    logic [BROAD_TYPE_WIDTH-1:0] type_q, type_d;
    logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
    logic [1:0]                  cpu_q, cpu_d;
    logic [BROAD_ID_WIDTH-1:0]   bid_q, bid_d;

    logic [3:0]                  gnt_onehot;
    logic [1:0]                  gnt_id;
    logic                        gnt_any;
    logic [BROAD_TYPE_WIDTH-1:0] win_type;
    logic [ADDR_WIDTH-1:0]       win_addr;
    logic                        win_bcast;

    mesi_isc_rr_arb4 u_rr_arb4 (
        .req_i        (breq_valid_i),
        .last_i       (last_grant_q),
        .gnt_onehot_o (gnt_onehot),
        .gnt_id_o     (gnt_id),
        .any_o        (gnt_any)
    );

    assign win_type  = breq_type_array_i[gnt_id*BROAD_TYPE_WIDTH +: BROAD_TYPE_WIDTH];
    assign win_addr  = breq_addr_array_i[gnt_id*ADDR_WIDTH +: ADDR_WIDTH];
    assign win_bcast = (win_type == TYPE_WR) || (win_type == TYPE_RD);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_cnt_d     = id_cnt_q;
        ack_d        = '0;
        wr_d         = 1'b0;
        type_d       = type_q;
        addr_d       = addr_q;
        cpu_d        = cpu_q;
        bid_d        = bid_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_any && !broad_fifo_full_i) begin
                    ack_d        = gnt_onehot;
                    last_grant_d = gnt_id;
                    state_d      = ST_GAP;
                    // NOP heads are popped and dropped without consuming an ID.
                    if (win_bcast) begin
                        wr_d     = 1'b1;
                        type_d   = win_type;
                        addr_d   = win_addr;
                        cpu_d    = gnt_id;
                        bid_d    = id_cnt_q;
                        id_cnt_d = id_cnt_q + BROAD_ID_WIDTH'(1);
                    end
                end
            end
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 2'd3;
            id_cnt_q     <= '0;
            ack_q        <= '0;
            wr_q         <= 1'b0;
            type_q       <= '0;
            addr_q       <= '0;
            cpu_q        <= '0;
            bid_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_cnt_q     <= id_cnt_d;
            ack_q        <= ack_d;
            wr_q         <= wr_d;
            type_q       <= type_d;
            addr_q       <= addr_d;
            cpu_q        <= cpu_d;
            bid_q        <= bid_d;
        end
    end

    assign breq_ack_o      = ack_q;
    assign broad_fifo_wr_o = wr_q;
    assign broad_type_o    = type_q;
    assign broad_addr_o    = addr_q;
    assign broad_cpu_id_o  = cpu_q;
    assign broad_id_o      = bid_q;

endmodule
